frame_scanout_fetcher: RTL and testbench

- Read-side client of the external-SRAM pixel store.
- Sweeps pixel addresses 0..FRAME_PIXELS-1 over the controller's read port (read_addr/read_data).
- Captures the returned 3-bit colours into a small prefetch FIFO and hands them to the VGA timing logic one pixel per pop.
- Sits between the SRAM controller and the VGA output stage; the Mandelbrot compute engine owns the write port.

---
 rtl/frame_scanout_fetcher.sv | 178 +++++++++++++++++
 tb/tb_frame_scanout_fetcher.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanout_fetcher.sv
// Purpose: sweeps SRAM pixel addresses, buffers the returned colours in a prefetch FIFO and pops one per pixel_req.
// Latency: RD_LATENCY clocks from read_addr to FIFO capture; 1 clock from pixel_req to pixel_color/pixel_valid.
// Backpressure: a read issues only while fifo_level + in-flight reads < FIFO_DEPTH; an empty pop flags underrun.
// Ports: clk/reset (sync, active-high); enable gates new reads; frame_start restarts at address 0 and flushes;
//        pixel_req pops -> pixel_color/pixel_valid; underrun is sticky; fifo_level is occupancy;
//        read_addr/read_data form the SRAM controller read port.
module frame_scanout_fetcher #(
    parameter int FRAME_PIXELS = 307200,
    parameter int RD_LATENCY   = 3,
    parameter int ADDR_HOLD    = 2,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        pixel_req,
    output logic [2:0]  pixel_color,
    output logic        pixel_valid,
    output logic        underrun,
    output logic [4:0]  fifo_level,
    output logic [18:0] read_addr,
    input  logic [2:0]  read_data
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(ADDR_HOLD);
    localparam logic [18:0] LAST_ADDR = 19'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_left_q, hold_left_d;
    logic [18:0]           addr_q, addr_d;
    logic [18:0]           next_addr_q, next_addr_d;
    logic [RD_LATENCY-1:0] tag_q, tag_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]            level_q, level_d;
    logic [2:0]            color_q, color_d;
    logic                  valid_q, valid_d;
    logic                  under_q, under_d;
    logic [2:0]            fifo_mem_q [FIFO_DEPTH];

    logic        capture, fifo_empty, credit, wr_en, rd_en;
    logic [4:0]  in_flight;
    logic [18:0] addr_inc;

    assign capture    = tag_q[RD_LATENCY-1];
    assign fifo_empty = (level_q == 5'd0);
    assign addr_inc   = (next_addr_q == LAST_ADDR) ? 19'd0 : next_addr_q + 19'd1;
    // Reads already tagged count against FIFO space so the FIFO can never overflow.
    assign credit     = ({1'b0, level_q} + {1'b0, in_flight}) < 6'(FIFO_DEPTH);

    always_comb begin
        in_flight = 5'd0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + 5'(tag_q[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_left_d = hold_left_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        // The tag enters during the issue cycle and reaches the top bit when read_data is valid.
        tag_d       = tag_q << 1;
        tag_d[0]    = (state_q == ISSUE);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        color_d     = color_q;
        valid_d     = 1'b0;
        under_d     = under_q;
        rd_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && credit) begin
                    state_d     = ISSUE;
                    addr_d      = next_addr_q;
                    next_addr_d = addr_inc;
                end
            end
            ISSUE: begin
                state_d     = HOLD;
                hold_left_d = HW'(ADDR_HOLD - 1);
            end
            HOLD: begin
                if (hold_left_q == HW'(1)) begin
                    if (enable && credit) begin
                        state_d     = ISSUE;
                        addr_d      = next_addr_q;
                        next_addr_d = addr_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_left_d = hold_left_q - HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (pixel_req) begin
            if (!fifo_empty) begin
                rd_en   = 1'b1;
                valid_d = 1'b1;
                color_d = fifo_mem_q[rd_ptr_q];
            end else if (capture) begin
                // Empty FIFO with a return arriving: pass it straight through, keeping order.
                valid_d = 1'b1;
                color_d = read_data;
            end else begin
                color_d = 3'd0;
                under_d = 1'b1;
            end
        end

        wr_en = capture && !(pixel_req && fifo_empty);
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        level_d = level_q + 5'(wr_en) - 5'(rd_en);

        // Restart overrides everything: in-flight returns are dropped and the pop sees an empty FIFO.
        if (frame_start) begin
            state_d     = enable ? ISSUE : IDLE;
            hold_left_d = '0;
            addr_d      = 19'd0;
            next_addr_d = enable ? ((LAST_ADDR == 19'd0) ? 19'd0 : 19'd1) : 19'd0;
            tag_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = 5'd0;
            valid_d     = 1'b0;
            under_d     = 1'b0;
            wr_en       = 1'b0;
            if (pixel_req) color_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_left_q <= '0;
            addr_q      <= 19'd0;
            next_addr_q <= 19'd0;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= 5'd0;
            color_q     <= 3'd0;
            valid_q     <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_left_q <= hold_left_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            color_q     <= color_d;
            valid_q     <= valid_d;
            under_q     <= under_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem_q[wr_ptr_q] <= read_data;
    end

    assign read_addr   = addr_q;
    assign pixel_color = color_q;
    assign pixel_valid = valid_q;
    assign underrun    = under_q;
    assign fifo_level  = level_q;
endmodule

// File: tb/tb_frame_scanout_fetcher.sv
// Purpose: directed bench for frame_scanout_fetcher with a queue/timestamp reference model and SRAM responder.
// Latency: model predicts every output for the cycle after each set of inputs.
// Backpressure: stimulus drives enable/pixel_req patterns; all loops are cycle-bounded.
module tb_frame_scanout_fetcher;
    localparam int FP    = 20;
    localparam int RDL   = 3;
    localparam int AH    = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, enable, frame_start, pixel_req;
    logic [2:0]  pixel_color;
    logic        pixel_valid, underrun;
    logic [4:0]  fifo_level;
    logic [18:0] read_addr;
    logic [2:0]  read_data;

    always #5 clk = ~clk;

    frame_scanout_fetcher #(
        .FRAME_PIXELS(FP), .RD_LATENCY(RDL), .ADDR_HOLD(AH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .pixel_req(pixel_req), .pixel_color(pixel_color), .pixel_valid(pixel_valid),
        .underrun(underrun), .fifo_level(fifo_level), .read_addr(read_addr),
        .read_data(read_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: outstanding reads carry the cycle their data is due.
    typedef struct packed {int due; int addr;} rd_t;
    rd_t pend[$];
    int  fifo[$];
    int  ahist[$];
    int  busy, m_addr, m_next, m_color;
    bit  m_valid, m_under;

    function automatic int colour(input int a);
        return a % 8;
    endfunction

    function automatic int inc(input int a);
        return (a + 1) % FP;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic model_step(input bit en, input bit fs, input bit req, input bit rst);
        int sum;
        bit cap;
        int capc;
        if (rst) begin
            pend.delete(); fifo.delete();
            busy = 0; m_addr = 0; m_next = 0; m_color = 0; m_valid = 0; m_under = 0;
            return;
        end
        sum = fifo.size() + pend.size();
        if (busy == AH) pend.push_back('{due: cyc + RDL, addr: m_addr});
        cap  = 0;
        capc = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            cap  = 1;
            capc = colour(pend[0].addr);
            pend.delete(0);
        end
        if (fs) begin
            pend.delete(); fifo.delete();
            m_valid = 0; m_under = 0; m_addr = 0;
            if (req) m_color = 0;
            if (en) begin busy = AH; m_next = inc(0); end
            else begin busy = 0; m_next = 0; end
            return;
        end
        m_valid = 0;
        if (req) begin
            if (fifo.size() > 0) begin
                m_color = fifo.pop_front(); m_valid = 1;
                if (cap) fifo.push_back(capc);
            end else if (cap) begin
                m_color = capc; m_valid = 1;
            end else begin
                m_color = 0; m_under = 1;
            end
        end else if (cap) begin
            fifo.push_back(capc);
        end
        if (busy > 1) busy--;
        else if (en && sum < DEPTH) begin busy = AH; m_addr = m_next; m_next = inc(m_next); end
        else busy = 0;
    endtask

    // One clock: act as the SRAM, drive inputs, advance the model, compare after the edge.
    task automatic step(input bit en, input bit fs, input bit req, input bit rst);
        ahist.push_back(int'(read_addr));
        read_data   = (ahist.size() > RDL) ? 3'(colour(ahist[ahist.size() - 1 - RDL])) : 3'd0;
        reset       = rst;
        enable      = en;
        frame_start = fs;
        pixel_req   = req;
        model_step(en, fs, req, rst);
        @(posedge clk);
        #1;
        cyc++;
        check("read_addr",   read_addr,   m_addr);
        check("fifo_level",  fifo_level,  fifo.size());
        check("pixel_valid", pixel_valid, int'(m_valid));
        check("pixel_color", pixel_color, m_color);
        check("underrun",    underrun,    int'(m_under));
    endtask

    initial begin
        int prev;
        bit found;
        reset = 1'b1; enable = 1'b0; frame_start = 1'b0; pixel_req = 1'b0; read_data = 3'd0;

        // Reset state
        repeat (3) step(0, 0, 0, 1);
        check("lit_reset_addr",  read_addr,   0);
        check("lit_reset_level", fifo_level,  0);
        check("lit_reset_valid", pixel_valid, 0);
        check("lit_reset_under", underrun,    0);

        // Fill with no pops: stalls after 16 issues, last issued address is 15
        repeat (50) step(1, 0, 0, 0);
        check("lit_fill_level", fifo_level, 16);
        check("lit_fill_addr",  read_addr,  15);

        // Pop one per two clocks; addresses wrap at FP-1
        step(1, 0, 1, 0);
        check("lit_first_pop_color", pixel_color, 0);
        check("lit_first_pop_valid", pixel_valid, 1);
        prev = int'(read_addr);
        for (int i = 0; i < 80; i++) begin
            step(1, 0, (i % 2) == 1, 0);
            if (prev == FP - 1 && int'(read_addr) != FP - 1) check("lit_wrap_to_zero", read_addr, 0);
            prev = int'(read_addr);
        end
        check("lit_steady_underrun", underrun, 0);

        // frame_start in the last hold cycle with 10 buffered and 2 in flight, pop in same cycle
        repeat (2) step(0, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (fifo.size() == 10 && pend.size() == 2 && busy == 1) begin found = 1; break; end
            step(1, 0, 0, 0);
        end
        check("reach_midhold", 32'(found), 1);
        step(1, 1, 1, 0);
        check("lit_fs_level", fifo_level,  0);
        check("lit_fs_addr",  read_addr,   0);
        check("lit_fs_valid", pixel_valid, 0);
        check("lit_fs_under", underrun,    0);
        repeat (10) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("lit_refill_pop_color", pixel_color, 0);
        check("lit_refill_pop_valid", pixel_valid, 1);
        step(1, 0, 1, 0);
        check("lit_refill_pop2_color", pixel_color, 1);

        // enable dropped right after an issue: that read still lands, nothing new issues
        step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        check("lit_drop1_level", fifo_level, 1);
        check("lit_drop1_addr",  read_addr,  0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        check("lit_drop2_level", fifo_level, 2);
        check("lit_drop2_addr",  read_addr,  1);
        step(0, 0, 1, 0);
        check("lit_drain_c0", pixel_color, 0);
        step(0, 0, 1, 0);
        check("lit_drain_c1", pixel_color, 1);
        step(0, 0, 1, 0);
        check("lit_drain_empty_valid", pixel_valid, 0);
        check("lit_drain_empty_under", underrun,    1);
        step(0, 0, 0, 0);
        check("lit_under_sticky", underrun, 1);

        // Pop every clock from reset: first pop underruns, write-through keeps order
        repeat (2) step(0, 0, 0, 1);
        step(1, 0, 1, 0);
        check("lit_early_pop_valid", pixel_valid, 0);
        check("lit_early_pop_under", underrun,    1);
        repeat (60) step(1, 0, 1, 0);

        // reset wins over frame_start
        step(1, 1, 1, 1);
        check("lit_rst_over_fs_under", underrun, 0);
        repeat (4) step(1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
